// File: rtl/fpu_selftest.sv
// On-chip stimulus/checker for the fpu block: replays a loadable vector memory through the fpu
// and compares each result against its expected value within an integer tolerance.
module fpu_selftest #(
  parameter int unsigned NUM_VECTORS = 10,
  parameter int unsigned AW          = 4,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned TOL         = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vec_we,
  input  logic [AW-1:0] vec_addr,
  input  logic [31:0]   vec_a,
  input  logic [31:0]   vec_b,
  input  logic [1:0]    vec_op,
  input  logic [31:0]   vec_exp,
  input  logic          start,
  input  logic          abort,
  output logic [31:0]   fpu_a,
  output logic [31:0]   fpu_b,
  output logic [1:0]    fpu_opcode,
  input  logic [31:0]   fpu_outp,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   fail_count,
  output logic [AW-1:0] first_fail_idx,
  output logic [31:0]   first_fail_out
);

  localparam int unsigned WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned FW = AW + 1;

  if (NUM_VECTORS < 1 || NUM_VECTORS > (1 << AW)) begin : g_bad_num_vectors
    $error("NUM_VECTORS must lie in 1..2^AW");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("LATENCY must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StApply, StWait, StCheck, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [31:0]     exp_q, exp_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [AW-1:0]   ffi_q, ffi_d;
  logic [31:0]     ffo_q, ffo_d;

  // Entry layout: {op[97:96], a[95:64], b[63:32], exp[31:0]}; not reset.
  logic [97:0]     mem [NUM_VECTORS];
  logic [97:0]     entry;
  logic [31:0]     diff;
  logic            mismatch;
  logic            running;

  assign running = (state_q == StApply) || (state_q == StWait) || (state_q == StCheck);

  always_ff @(posedge clk) begin
    if (vec_we && !running && (32'(vec_addr) < NUM_VECTORS)) begin
      mem[vec_addr] <= {vec_op, vec_a, vec_b, vec_exp};
    end
  end

  assign entry = mem[idx_q];

  // Absolute difference taken on the larger-minus-smaller so it never wraps.
  always_comb begin
    diff = '0;
    if (exp_q >= fpu_outp) begin
      diff = exp_q - fpu_outp;
    end else begin
      diff = fpu_outp - exp_q;
    end
    mismatch = (diff > TOL);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    exp_d   = exp_q;
    fcnt_d  = fcnt_q;
    ffi_d   = ffi_q;
    ffo_d   = ffo_q;

    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StApply;
            idx_d   = '0;
            fcnt_d  = '0;
            ffi_d   = '0;
            ffo_d   = '0;
          end
        end
        StApply: begin
          op_d    = entry[97:96];
          a_d     = entry[95:64];
          b_d     = entry[63:32];
          exp_d   = entry[31:0];
          wcnt_d  = WW'(LATENCY - 1);
          state_d = StWait;
        end
        StWait: begin
          if (wcnt_q == '0) begin
            state_d = StCheck;
          end else begin
            wcnt_d = wcnt_q - 1'b1;
          end
        end
        StCheck: begin
          if (mismatch) begin
            if (fcnt_q == '0) begin
              ffi_d = idx_q;
              ffo_d = fpu_outp;
            end
            if (fcnt_q != '1) begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
          if (idx_q == AW'(NUM_VECTORS - 1)) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StApply;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      exp_q   <= '0;
      fcnt_q  <= '0;
      ffi_q   <= '0;
      ffo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      exp_q   <= exp_d;
      fcnt_q  <= fcnt_d;
      ffi_q   <= ffi_d;
      ffo_q   <= ffo_d;
    end
  end

  assign fpu_a          = a_q;
  assign fpu_b          = b_q;
  assign fpu_opcode     = op_q;
  assign busy           = running;
  assign done           = (state_q == StDone);
  assign pass           = done && (fcnt_q == '0);
  assign fail_count     = fcnt_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_out = ffo_q;

endmodule
